parking_lot_ctrl: RTL and testbench
===================================

PARKING_LOT_CTRL -- requirements
Module: parking_lot_ctrl

Interface
REQ-001 SHALL have parameter N_SPOTS, default 9, number of parking spots (2..16).
REQ-002 SHALL have parameter SIZE_MAP, default {2'd2,2'd1,2'd1,6{2'd0}} (spot 8 large, spots 7..6 medium, spots 5..0 small), packed 2 bits per spot, spot i at [2i+1:2i].
REQ-003 SHALL have parameter TIME_W, default 9, width of the time counter.
REQ-004 SHALL have parameter RATE, default 1, fare units per elapsed tick.
REQ-005 SHALL have input clock, 1 bit, the system clock.
REQ-006 SHALL have input resetn, 1 bit; reset resetn, synchronous, active-low; clock clock.
REQ-007 SHALL have input tick, 1 bit, a one-cycle time-base pulse.
REQ-008 SHALL have input req_valid, 1 bit, request strobe.
REQ-009 SHALL have output req_ready, 1 bit, request accepted when req_valid is also high.
REQ-010 SHALL have input req_park, 1 bit: 1 = park, 0 = pick.
REQ-011 SHALL have input req_spot, 4 bits, target spot index.
REQ-012 SHALL have input req_size, 2 bits: 0 = car, 1 = van, 2 = bus, 3 = invalid.
REQ-013 SHALL have output resp_valid, 1 bit, a one-cycle response strobe.
REQ-014 SHALL have output resp_code, 3 bits: 0 OK, 1 OCCUPIED, 2 EMPTY, 3 NOFIT, 4 BADSPOT.
REQ-015 SHALL have output resp_fare, TIME_W+8 bits, fare for a successful pick, otherwise 0.
REQ-016 SHALL have output occupied, N_SPOTS bits, per-spot occupancy.
REQ-017 SHALL have output free_count, 5 bits, number of unoccupied spots.
REQ-018 SHALL have output lot_full, 1 bit, high when free_count == 0.

Function
REQ-019 SHALL implement the FSM IDLE -> CHECK -> DONE -> IDLE; req_ready = 1 only in IDLE.
REQ-020 SHALL capture req_park, req_spot and req_size at the edge where req_valid & req_ready, then enter CHECK.
- Inputs are ignored outside IDLE.
REQ-021 SHALL, in CHECK, evaluate the captured request in priority order:
- req_spot >= N_SPOTS -> BADSPOT
- park with spot occupied -> OCCUPIED
- park with req_size == 3 or req_size > SIZE_MAP class of the spot -> NOFIT
- pick with spot empty -> EMPTY
- otherwise -> OK
REQ-022 SHALL, on the CHECK->DONE edge, register resp_code and resp_fare and apply the occupancy update.
- Park OK: set occupied[spot], store start[spot] = now.
- Pick OK: clear occupied[spot].
- Any other code: occupancy and start times unchanged.
REQ-023 SHALL assert resp_valid for exactly the single DONE cycle.
- Acceptance at edge k gives resp_valid high in cycle k+2.
- The next acceptance occurs no earlier than edge k+3.
REQ-024 SHALL maintain now, a TIME_W-bit counter that increments by 1 on each clock with tick = 1 and wraps from 2^TIME_W-1 to 0.
REQ-025 SHALL compute the pick fare as ((now - start[spot]) mod 2^TIME_W) * RATE, zero-extended to TIME_W+8 bits and saturated at all-ones on overflow.
REQ-026 SHALL, when tick coincides with the commit edge, store or use the pre-increment value of now.
REQ-027 SHALL keep resp_code and resp_fare stable after DONE until the next commit.
REQ-028 SHALL derive free_count and lot_full combinationally from occupied.
REQ-029 SHALL leave a park request to a full lot to follow REQ-021 (OCCUPIED); no global rejection exists.

Reset
REQ-030 SHALL, when resetn = 0 at a clock edge, set:
- state = IDLE
- occupied = 0
- now = 0
- all start[] = 0
- resp_valid = 0
- resp_code = 0
- resp_fare = 0
REQ-031 SHALL treat reset during CHECK or DONE as abandoning the transaction: no occupancy change, no resp_valid.
REQ-032 SHALL hold free_count = N_SPOTS, lot_full = 0 and req_ready = 1 in the first cycle after reset release.

Verification
REQ-033 SHALL cover: after reset, park car (size 0) at spot 3 -> resp_valid 2 cycles after accept, code 0, occupied = 9'h008, free_count = 8.
REQ-034 SHALL cover: park bus (size 2) at spot 6 -> code 3 (NOFIT); park bus at spot 8 -> code 0, occupied[8] = 1.
REQ-035 SHALL cover: park at spot 3 at now = 5, issue 20 ticks, pick spot 3 -> code 0, resp_fare = 20 (RATE 1), occupied[3] = 0.
REQ-036 SHALL cover wrap: park at now = 510, issue 10 ticks, pick -> resp_fare = 10.
REQ-037 SHALL cover: pick empty spot 2 -> code 2; request spot 12 -> code 4; park occupied spot 3 -> code 1; occupied unchanged in all three.
REQ-038 SHALL cover: fill all 9 spots -> lot_full = 1, free_count = 0; assert resetn = 0 during a CHECK -> no resp_valid, all outputs at reset values.

Source files
------------

// File: rtl/parking_lot_ctrl.sv
// Parking lot controller: validates park/pick requests against per-spot size
// class and occupancy, tracks elapsed ticks per spot and reports a fare on pick.
module parking_lot_ctrl #(
  parameter int unsigned           N_SPOTS  = 9,
  parameter logic [2*N_SPOTS-1:0]  SIZE_MAP = {2'd2, 2'd1, 2'd1, {6{2'd0}}},
  parameter int unsigned           TIME_W   = 9,
  parameter int unsigned           RATE     = 1
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 tick,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_park,
  input  logic [3:0]           req_spot,
  input  logic [1:0]           req_size,
  output logic                 resp_valid,
  output logic [2:0]           resp_code,
  output logic [TIME_W+7:0]    resp_fare,
  output logic [N_SPOTS-1:0]   occupied,
  output logic [4:0]           free_count,
  output logic                 lot_full
);

  localparam int unsigned FW = TIME_W + 8;
  localparam int unsigned PW = TIME_W + 32;

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_e;
  typedef enum logic [2:0] {
    RC_OK       = 3'd0,
    RC_OCCUPIED = 3'd1,
    RC_EMPTY    = 3'd2,
    RC_NOFIT    = 3'd3,
    RC_BADSPOT  = 3'd4
  } code_e;

  state_e              state, state_next;
  logic                cap_park;
  logic [3:0]          cap_spot;
  logic [1:0]          cap_size;
  logic [TIME_W-1:0]   now;
  logic [TIME_W-1:0]   start_time [N_SPOTS];
  logic [N_SPOTS-1:0]  occ;

  logic                sel_occ;
  logic [1:0]          sel_class;
  logic [TIME_W-1:0]   sel_start;
  logic                in_range;
  code_e               code;
  logic [TIME_W-1:0]   elapsed;
  logic [PW-1:0]       product;
  logic [FW-1:0]       fare;
  logic [4:0]          free_cnt;

  // FSM: state register
  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (req_valid) state_next = CHECK;
      CHECK:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == DONE);
  end

  // Spot lookup done by comparison so out-of-range indices never address the arrays
  always_comb begin
    sel_occ   = 1'b0;
    sel_class = '0;
    sel_start = '0;
    for (int unsigned i = 0; i < N_SPOTS; i++) begin
      if (32'(cap_spot) == i) begin
        sel_occ   = occ[i];
        sel_class = SIZE_MAP[2*i +: 2];
        sel_start = start_time[i];
      end
    end
  end

  always_comb begin
    in_range = (32'(cap_spot) < N_SPOTS);
    if (!in_range)                                   code = RC_BADSPOT;
    else if (cap_park && sel_occ)                    code = RC_OCCUPIED;
    else if (cap_park && (cap_size == 2'd3 || cap_size > sel_class))
                                                     code = RC_NOFIT;
    else if (!cap_park && !sel_occ)                  code = RC_EMPTY;
    else                                             code = RC_OK;
  end

  always_comb begin
    elapsed = now - sel_start;
    product = PW'(elapsed) * PW'(RATE);
    fare    = (|product[PW-1:FW]) ? '1 : product[FW-1:0];
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      now       <= '0;
      occ       <= '0;
      resp_code <= '0;
      resp_fare <= '0;
      cap_park  <= 1'b0;
      cap_spot  <= '0;
      cap_size  <= '0;
      for (int unsigned i = 0; i < N_SPOTS; i++) start_time[i] <= '0;
    end else begin
      if (tick) now <= now + TIME_W'(1);
      if (state == IDLE && req_valid) begin
        cap_park <= req_park;
        cap_spot <= req_spot;
        cap_size <= req_size;
      end
      // Commit uses the pre-increment value of now even when tick coincides
      if (state == CHECK) begin
        resp_code <= code;
        resp_fare <= (code == RC_OK && !cap_park) ? fare : '0;
        if (code == RC_OK) begin
          for (int unsigned i = 0; i < N_SPOTS; i++) begin
            if (32'(cap_spot) == i) begin
              occ[i] <= cap_park;
              if (cap_park) start_time[i] <= now;
            end
          end
        end
      end
    end
  end

  always_comb begin
    free_cnt = '0;
    for (int unsigned i = 0; i < N_SPOTS; i++) begin
      if (!occ[i]) free_cnt = free_cnt + 5'd1;
    end
  end

  assign occupied   = occ;
  assign free_count = free_cnt;
  assign lot_full   = (free_cnt == 5'd0);

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Randomized bench for parking_lot_ctrl against a behavioural lot model.
module tb_parking_lot_ctrl;

  localparam int TW = 9;
  localparam int NS = 9;
  localparam int MOD = 1 << TW;
  localparam int FARE_MAX = (1 << (TW + 8)) - 1;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          tick = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_park = 1'b0;
  logic [3:0]    req_spot = '0;
  logic [1:0]    req_size = '0;
  logic          resp_valid;
  logic [2:0]    resp_code;
  logic [TW+7:0] resp_fare;
  logic [NS-1:0] occupied;
  logic [4:0]    free_count;
  logic          lot_full;

  int checks = 0;
  int failures = 0;

  int m_now;
  bit m_occ [16];
  int m_start [16];
  int m_code;
  int m_fare;

  parking_lot_ctrl #(.N_SPOTS(NS), .TIME_W(TW), .RATE(1)) dut (
    .clock(clock), .resetn(resetn), .tick(tick),
    .req_valid(req_valid), .req_ready(req_ready), .req_park(req_park),
    .req_spot(req_spot), .req_size(req_size),
    .resp_valid(resp_valid), .resp_code(resp_code), .resp_fare(resp_fare),
    .occupied(occupied), .free_count(free_count), .lot_full(lot_full)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int size_class(input int s);
    if (s == 8) return 2;
    if (s >= 6) return 1;
    return 0;
  endfunction

  function automatic int occ_vec();
    int v = 0;
    for (int i = 0; i < NS; i++) if (m_occ[i]) v |= (1 << i);
    return v;
  endfunction

  function automatic int n_free();
    int n = 0;
    for (int i = 0; i < NS; i++) if (!m_occ[i]) n++;
    return n;
  endfunction

  // One clock edge; the model time base follows the inputs seen at that edge
  task automatic clk_edge();
    @(posedge clock);
    if (!resetn) begin
      m_now = 0;
      for (int i = 0; i < 16; i++) begin m_occ[i] = 0; m_start[i] = 0; end
      m_code = 0;
      m_fare = 0;
    end else if (tick) begin
      m_now = (m_now + 1) % MOD;
    end
    #1;
  endtask

  task automatic rand_tick(input bit rnd);
    tick = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic ticks(input int n);
    req_valid = 1'b0;
    tick = 1'b1;
    repeat (n) clk_edge();
    tick = 1'b0;
  endtask

  task automatic check_lot(input string tag);
    check({tag, "_occ"}, 32'(occupied), occ_vec());
    check({tag, "_free"}, 32'(free_count), n_free());
    check({tag, "_full"}, 32'(lot_full), (n_free() == 0) ? 1 : 0);
  endtask

  task automatic do_req(input bit park, input int spot, input int size, input bit rnd);
    int e;
    check("ready_idle", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_park  = park;
    req_spot  = 4'(spot);
    req_size  = 2'(size);
    rand_tick(rnd);
    clk_edge();
    // Garbage on the request inputs must be ignored while busy
    req_valid = 1'($urandom_range(0, 1));
    req_park  = 1'($urandom_range(0, 1));
    req_spot  = 4'($urandom_range(0, 15));
    req_size  = 2'($urandom_range(0, 3));
    rand_tick(rnd);
    check("check_valid", 32'(resp_valid), 0);
    check("check_ready", 32'(req_ready), 0);

    if (spot >= NS)                                   e = 4;
    else if (park && m_occ[spot])                     e = 1;
    else if (park && (size == 3 || size > size_class(spot))) e = 3;
    else if (!park && !m_occ[spot])                   e = 2;
    else                                              e = 0;
    m_code = e;
    m_fare = 0;
    if (e == 0) begin
      if (park) begin
        m_occ[spot] = 1;
        m_start[spot] = m_now;
      end else begin
        m_occ[spot] = 0;
        m_fare = ((m_now - m_start[spot]) % MOD + MOD) % MOD;
        if (m_fare > FARE_MAX) m_fare = FARE_MAX;
      end
    end
    clk_edge();
    req_valid = 1'b0;
    rand_tick(rnd);
    check("done_valid", 32'(resp_valid), 1);
    check("done_code", 32'(resp_code), m_code);
    check("done_fare", 32'(resp_fare), m_fare);
    check_lot("done");
    clk_edge();
    check("post_valid", 32'(resp_valid), 0);
    check("post_code", 32'(resp_code), m_code);
    check("post_fare", 32'(resp_fare), m_fare);
    tick = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    repeat (2) clk_edge();
    check("rst_valid", 32'(resp_valid), 0);
    check("rst_code", 32'(resp_code), 0);
    check("rst_fare", 32'(resp_fare), 0);
    check("rst_occ", 32'(occupied), 0);
    resetn = 1'b1;
    clk_edge();
    check("rel_ready", 32'(req_ready), 1);
    check("rel_free", 32'(free_count), NS);
    check("rel_full", 32'(lot_full), 0);

    ticks(5);
    do_req(1'b1, 3, 0, 1'b0);
    check("park3_code", 32'(resp_code), 0);
    check("park3_occ", 32'(occupied), 32'h008);
    check("park3_free", 32'(free_count), 8);

    do_req(1'b1, 6, 2, 1'b0);
    check("bus6_nofit", 32'(resp_code), 3);
    do_req(1'b1, 8, 2, 1'b0);
    check("bus8_ok", 32'(resp_code), 0);
    check("bus8_occ", 32'(occupied[8]), 1);

    do_req(1'b0, 2, 0, 1'b0);
    check("pick2_empty", 32'(resp_code), 2);
    do_req(1'b1, 12, 0, 1'b0);
    check("spot12_bad", 32'(resp_code), 4);
    do_req(1'b1, 3, 1, 1'b0);
    check("park3_occupied", 32'(resp_code), 1);
    check("errs_occ", 32'(occupied), 32'h108);

    ticks(20);
    do_req(1'b0, 3, 0, 1'b0);
    check("fare20_code", 32'(resp_code), 0);
    check("fare20", 32'(resp_fare), 20);
    check("fare20_occ3", 32'(occupied[3]), 0);

    ticks(510 - m_now);
    do_req(1'b1, 3, 0, 1'b0);
    ticks(10);
    do_req(1'b0, 3, 0, 1'b0);
    check("wrap_fare10", 32'(resp_fare), 10);

    repeat (300) begin
      int spot;
      spot = ($urandom_range(0, 7) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      do_req(1'($urandom_range(0, 1)), spot, int'($urandom_range(0, 3)), 1'b1);
      if ($urandom_range(0, 9) == 0) ticks(int'($urandom_range(1, 40)));
    end

    for (int s = 0; s < NS; s++) do_req(1'b1, s, 0, 1'b1);
    check("full_flag", 32'(lot_full), 1);
    check("full_free", 32'(free_count), 0);
    do_req(1'b1, 4, 0, 1'b1);
    check("full_occupied", 32'(resp_code), 1);

    check("abort_ready", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_park  = 1'b0;
    req_spot  = 4'd0;
    req_size  = 2'd0;
    clk_edge();
    req_valid = 1'b0;
    resetn = 1'b0;
    clk_edge();
    check("abort_valid", 32'(resp_valid), 0);
    check("abort_code", 32'(resp_code), 0);
    check("abort_fare", 32'(resp_fare), 0);
    check("abort_occ", 32'(occupied), 0);
    check("abort_free", 32'(free_count), NS);
    check("abort_full", 32'(lot_full), 0);
    resetn = 1'b1;
    clk_edge();
    check("abort_valid2", 32'(resp_valid), 0);
    check("abort_ready2", 32'(req_ready), 1);
    do_req(1'b1, 7, 1, 1'b1);
    check("resume_code", 32'(resp_code), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
